// File: rtl/st_encoder_pkg.sv
// Shared types and helpers for the streaming encoder stages.
// Byte-serializer additions: byte width, beat-to-byte helper, byte type, FSM states.
package st_encoder_pkg;

  localparam int ST_BYTE_W = 8;

  typedef logic [ST_BYTE_W-1:0] st_byte_t;

  // Byte serializer: EMPTY holds nothing, SEND is presenting bytes of the held beat
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SEND  = 1'b1
  } ser_state_t;

  // Number of whole bytes carried by one beat of the given bit width
  function automatic int bytes_per_beat(input int width);
    return width / ST_BYTE_W;
  endfunction

endpackage

// File: rtl/st_pkt_beat_hold.sv
// Beat holding register for the byte serializer.
// Captures beat data, sop/eop and the index of the last valid byte on load.
module st_pkt_beat_hold
  import st_encoder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NB    = bytes_per_beat(WIDTH),
  parameter int LW    = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [LW-1:0]    in_len,
  output logic [WIDTH-1:0] held_data,
  output logic             held_sop,
  output logic             held_eop,
  output logic [LW-1:0]    held_last
);

  logic [LW-1:0] last_calc;

  // Last byte index (nbytes-1); len only counts on eop beats, 0 meaning a full beat
  always_comb begin
    last_calc = LW'(NB - 1);
    if (in_eop && (in_len != '0)) begin
      last_calc = in_len - LW'(1);
    end
  end

  // Capture the accepted beat and its byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      held_data <= '0;
      held_sop  <= 1'b0;
      held_eop  <= 1'b0;
      held_last <= '0;
    end else if (load) begin
      held_data <= in_data;
      held_sop  <= in_sop;
      held_eop  <= in_eop;
      held_last <= last_calc;
    end
  end

endmodule

// File: rtl/st_pkt_byte_serializer.sv
// Packet beat to byte stream serializer, one byte per cycle, no bubble across beats.
// Optional protocol checker enabled by defining ST_PKT_PROTO_CHECK_EN.
module st_pkt_byte_serializer
  import st_encoder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic                         i_sop,
  input  logic                         i_eop,
  input  logic [WIDTH-1:0]             i_data,
  input  logic [$clog2(WIDTH/8)-1:0]   i_len,
  output logic                         o_valid,
  input  logic                         o_ready,
  output st_byte_t                     o_data,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic                         o_err
);

  localparam int NB = bytes_per_beat(WIDTH);
  localparam int LW = $clog2(NB);

  ser_state_t       state, state_nxt;
  logic [LW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] held_data;
  logic             held_sop;
  logic             held_eop;
  logic [LW-1:0]    held_last;
  logic             accept;
  logic             take;
  logic             last;
  logic             keep;

  st_pkt_beat_hold #(
    .WIDTH (WIDTH),
    .NB    (NB),
    .LW    (LW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (keep),
    .in_data   (i_data),
    .in_sop    (i_sop),
    .in_eop    (i_eop),
    .in_len    (i_len),
    .held_data (held_data),
    .held_sop  (held_sop),
    .held_eop  (held_eop),
    .held_last (held_last)
  );

`ifdef ST_PKT_PROTO_CHECK_EN
  logic in_pkt;
  logic drop;
  logic restart;
  logic err_q;

  // Classify accepted beats against packet framing
  always_comb begin
    drop    = accept && !i_sop && !in_pkt;
    restart = accept && i_sop && in_pkt;
    keep    = accept && !drop;
  end

  // Track packet framing and pulse o_err for one cycle on a violation
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= drop || restart;
      if (accept && !drop) begin
        in_pkt <= !i_eop;
      end
    end
  end

  assign o_err = err_q;
`else
  // Every accepted beat is loaded unchecked
  always_comb begin
    keep = accept;
  end

  assign o_err = 1'b0;
`endif

  // Handshake terms: i_ready depends only on registered state and o_ready
  always_comb begin
    last    = (idx == held_last);
    o_valid = (state == S_SEND);
    i_ready = (state == S_EMPTY) || ((state == S_SEND) && last && o_ready);
    accept  = i_valid && i_ready;
    take    = o_valid && o_ready;
  end

  // Next state and byte index; a beat loaded on the last byte restarts at index 0
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_EMPTY: begin
        if (keep) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (take) begin
          if (last) begin
            state_nxt = keep ? S_SEND : S_EMPTY;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + LW'(1);
          end
        end
      end
      default: begin
        state_nxt = S_EMPTY;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and byte index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Output byte select, most significant byte first; framing gated by o_valid
  always_comb begin
    o_data = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (idx == LW'(b)) begin
        o_data = held_data[WIDTH-1-ST_BYTE_W*b -: ST_BYTE_W];
      end
    end
    o_sop = o_valid && held_sop && (idx == '0);
    o_eop = o_valid && held_eop && last;
  end

endmodule

// File: tb/tb_st_pkt_byte_serializer.sv
// Directed self-checking bench for st_pkt_byte_serializer (WIDTH=32).
module tb_st_pkt_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic        i_sop;
  logic        i_eop;
  logic [31:0] i_data;
  logic [1:0]  i_len;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_sop;
  logic        o_eop;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;

  st_pkt_byte_serializer #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_sop   (i_sop),
    .i_eop   (i_eop),
    .i_data  (i_data),
    .i_len   (i_len),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one presented byte, then advance a cycle
  task automatic exp_byte(input string tag, input logic [7:0] d, input logic s, input logic e);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".data"},  32'(o_data),  32'(d));
    chk({tag, ".sop"},   32'(o_sop),   32'(s));
    chk({tag, ".eop"},   32'(o_eop),   32'(e));
    tick();
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] l);
    i_valid = 1'b1;
    i_data  = d;
    i_sop   = s;
    i_eop   = e;
    i_len   = l;
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    i_data  = '0;
    i_len   = '0;
  endtask

  initial begin
    rst = 1'b1;
    o_ready = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.sop",   32'(o_sop),   32'd0);
    chk("rst.eop",   32'(o_eop),   32'd0);
    chk("rst.data",  32'(o_data),  32'd0);
    chk("rst.err",   32'(o_err),   32'd0);
    chk("rst.iready", 32'(i_ready), 32'd1);

    // Test 1: single full beat
    drive_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0);
    tick();
    idle_in();
    exp_byte("t1.b0", 8'hA1, 1'b1, 1'b0);
    exp_byte("t1.b1", 8'hB2, 1'b0, 1'b0);
    exp_byte("t1.b2", 8'hC3, 1'b0, 1'b0);
    exp_byte("t1.b3", 8'hD4, 1'b0, 1'b1);
    chk("t1.idle", 32'(o_valid), 32'd0);

    // Test 2: two-beat packet, second beat accepted on last byte of first
    drive_beat(32'h01020304, 1'b1, 1'b0, 2'd0);
    tick();
    drive_beat(32'h05060708, 1'b0, 1'b1, 2'd2);
    chk("t2.iready0", 32'(i_ready), 32'd0);
    exp_byte("t2.b0", 8'h01, 1'b1, 1'b0);
    exp_byte("t2.b1", 8'h02, 1'b0, 1'b0);
    exp_byte("t2.b2", 8'h03, 1'b0, 1'b0);
    chk("t2.iready3", 32'(i_ready), 32'd1);
    exp_byte("t2.b3", 8'h04, 1'b0, 1'b0);
    idle_in();
    exp_byte("t2.b4", 8'h05, 1'b0, 1'b0);
    exp_byte("t2.b5", 8'h06, 1'b0, 1'b1);
    chk("t2.idle", 32'(o_valid), 32'd0);

    // Test 3: backpressure on byte 2
    drive_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0);
    tick();
    idle_in();
    exp_byte("t3.b0", 8'hA1, 1'b1, 1'b0);
    exp_byte("t3.b1", 8'hB2, 1'b0, 1'b0);
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3.hold.valid", 32'(o_valid), 32'd1);
      chk("t3.hold.data",  32'(o_data),  32'hC3);
      chk("t3.hold.iready", 32'(i_ready), 32'd0);
      tick();
    end
    o_ready = 1'b1;
    exp_byte("t3.b2", 8'hC3, 1'b0, 1'b0);
    exp_byte("t3.b3", 8'hD4, 1'b0, 1'b1);
    chk("t3.idle", 32'(o_valid), 32'd0);

    // Test 4: reset mid-packet, then fresh packets including len boundaries
    drive_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0);
    tick();
    idle_in();
    exp_byte("t4.b0", 8'hA1, 1'b1, 1'b0);
    exp_byte("t4.b1", 8'hB2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4.rst.valid",  32'(o_valid), 32'd0);
    chk("t4.rst.iready", 32'(i_ready), 32'd1);
    drive_beat(32'h5A6B7C8D, 1'b1, 1'b1, 2'd3);
    tick();
    idle_in();
    exp_byte("t4.n0", 8'h5A, 1'b1, 1'b0);
    exp_byte("t4.n1", 8'h6B, 1'b0, 1'b0);
    exp_byte("t4.n2", 8'h7C, 1'b0, 1'b1);
    chk("t4.n.idle", 32'(o_valid), 32'd0);
    drive_beat(32'hEE112233, 1'b1, 1'b1, 2'd1);
    tick();
    idle_in();
    exp_byte("t4.one", 8'hEE, 1'b1, 1'b1);
    chk("t4.one.idle", 32'(o_valid), 32'd0);

    // Tests 5/6: beat without sop after idle
    drive_beat(32'h11223344, 1'b0, 1'b1, 2'd0);
    tick();
    idle_in();
`ifdef ST_PKT_PROTO_CHECK_EN
    chk("t5.valid",  32'(o_valid), 32'd0);
    chk("t5.err",    32'(o_err),   32'd1);
    chk("t5.iready", 32'(i_ready), 32'd1);
    tick();
    chk("t5.err.off",  32'(o_err),   32'd0);
    chk("t5.valid2",   32'(o_valid), 32'd0);
`else
    chk("t6.err0", 32'(o_err), 32'd0);
    exp_byte("t6.b0", 8'h11, 1'b0, 1'b0);
    exp_byte("t6.b1", 8'h22, 1'b0, 1'b0);
    exp_byte("t6.b2", 8'h33, 1'b0, 1'b0);
    chk("t6.err3", 32'(o_err), 32'd0);
    exp_byte("t6.b3", 8'h44, 1'b0, 1'b1);
    chk("t6.idle", 32'(o_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
